// File: rtl/comm_pkg.sv
// Shared types and constants for the host-side command master and its serializer.
package comm_pkg;

    localparam int DEFAULT_BAUD_CNT = 2604;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serializer. A new byte may be accepted in the last cycle of the
// current stop bit, which lets back-to-back frames run without an idle gap.
module uart_tx
    import comm_pkg::*;
#(
    parameter int BAUD_CNT = DEFAULT_BAUD_CNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_CNT - 1);

    logic        busy_reg;
    logic [9:0]  shft_reg;
    logic [11:0] baud_cnt_reg;
    logic [3:0]  bit_cnt_reg;

    logic baud_end;
    logic load;

    assign baud_end = busy_reg && (baud_cnt_reg == BAUD_LAST);
    assign tx_done  = baud_end && (bit_cnt_reg == 4'd9);
    assign load     = trmt && (!busy_reg || tx_done);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy_reg     <= 1'b0;
            shft_reg     <= '1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (load) begin
            busy_reg     <= 1'b1;
            shft_reg     <= {1'b1, tx_data, 1'b0};
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (tx_done) begin
            busy_reg     <= 1'b0;
            shft_reg     <= '1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (baud_end) begin
            // Shifting in ones keeps the line high once the stop bit is out.
            shft_reg     <= {1'b1, shft_reg[9:1]};
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
        end else if (busy_reg) begin
            baud_cnt_reg <= baud_cnt_reg + 12'd1;
        end
    end

    // Driven straight from a flop so the serial line never glitches.
    assign TX = shft_reg[0];

endmodule

// File: rtl/comm_master.sv
// Host-side command master: sends 16-bit commands as two 8N1 bytes and receives
// single response bytes. COMM_MASTER_FRAME_CHECK_EN drops frames with a low stop bit.
module comm_master
    import comm_pkg::*;
#(
    parameter int BAUD_CNT = DEFAULT_BAUD_CNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        cmd_cmplt,
    input  logic        RX,
    output logic        rdy,
    output logic [7:0]  rx_data,
    input  logic        clr_rdy
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_CNT - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_CNT / 2 - 1);

    tx_state_t   state_reg, state_next;
    logic [7:0]  cmd_low_reg;
    logic        cmd_cmplt_reg;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        cmd_load;
    logic        cmplt_set;

    uart_tx #(
        .BAUD_CNT (BAUD_CNT)
    ) u_uart_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

    // The high byte goes to the serializer in the same cycle the command is
    // captured, so only the low byte needs holding for later.
    always_comb begin
        state_next = state_reg;
        trmt       = 1'b0;
        tx_data    = cmd_low_reg;
        cmd_load   = 1'b0;
        cmplt_set  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (snd_cmd) begin
                    trmt       = 1'b1;
                    tx_data    = cmd[15:8];
                    cmd_load   = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (tx_done) begin
                    trmt       = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (tx_done) begin
                    cmplt_set  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg     <= IDLE;
            cmd_low_reg   <= '0;
            cmd_cmplt_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (cmd_load) begin
                cmd_low_reg   <= cmd[7:0];
                cmd_cmplt_reg <= 1'b0;
            end else if (cmplt_set) begin
                cmd_cmplt_reg <= 1'b1;
            end
        end
    end

    assign cmd_cmplt = cmd_cmplt_reg;

    rx_state_t   rx_state_reg, rx_state_next;
    logic        rx_ff1_reg, rx_sync_reg, rx_prev_reg;
    logic [11:0] rx_cnt_reg, rx_cnt_next;
    logic [3:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shft_reg, rx_shft_next;
    logic [7:0]  rx_data_reg, rx_data_next;
    logic        rdy_reg, rdy_next;
    logic        start_det;
    logic        rdy_set;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shft_next  = rx_shft_reg;
        rx_data_next  = rx_data_reg;
        start_det     = 1'b0;
        rdy_set       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    start_det     = 1'b1;
                    rx_state_next = RX_RECV;
                    rx_cnt_next   = HALF_LAST;
                    rx_bit_next   = '0;
                end
            end
            RX_RECV: begin
                if (rx_cnt_reg == 12'd0) begin
                    // Sample 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
                    rx_cnt_next = BAUD_LAST;
                    rx_bit_next = rx_bit_reg + 4'd1;
                    if (rx_bit_reg == 4'd9) begin
                        rx_state_next = RX_IDLE;
`ifdef COMM_MASTER_FRAME_CHECK_EN
                        if (rx_sync_reg) begin
                            rx_data_next = rx_shft_reg;
                            rdy_set      = 1'b1;
                        end
`else
                        rx_data_next = rx_shft_reg;
                        rdy_set      = 1'b1;
`endif
                    end else if (rx_bit_reg != 4'd0) begin
                        rx_shft_next = {rx_sync_reg, rx_shft_reg[7:1]};
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - 12'd1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase

        // A delivery in the same cycle as a clear must leave the byte flagged.
        if (rdy_set) begin
            rdy_next = 1'b1;
        end else if (clr_rdy || start_det) begin
            rdy_next = 1'b0;
        end else begin
            rdy_next = rdy_reg;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_ff1_reg   <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shft_reg  <= '0;
            rx_data_reg  <= '0;
            rdy_reg      <= 1'b0;
        end else begin
            rx_ff1_reg   <= RX;
            rx_sync_reg  <= rx_ff1_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shft_reg  <= rx_shft_next;
            rx_data_reg  <= rx_data_next;
            rdy_reg      <= rdy_next;
        end
    end

    assign rdy     = rdy_reg;
    assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_comm_master.sv
// Directed bench for comm_master at BAUD_CNT=16: table-driven RX and TX vectors
// plus hand sequences for timing, ignored requests, loopback and mid-frame reset.
module tb_comm_master;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        clr_rdy = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        RX;
    logic        TX;
    logic        cmd_cmplt;
    logic        rdy;
    logic [7:0]  rx_data;

    int checks = 0;
    int failures = 0;
    logic [7:0] txq[$];

    assign RX = loop_en ? TX : rx_drv;

    always #5 clk = ~clk;

    comm_master #(
        .BAUD_CNT (BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .snd_cmd   (snd_cmd),
        .TX        (TX),
        .cmd_cmplt (cmd_cmplt),
        .RX        (RX),
        .rdy       (rdy),
        .rx_data   (rx_data),
        .clr_rdy   (clr_rdy)
    );

    // Independent 8N1 decoder on TX, sampling mid-bit on falling clock edges.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = 8'h00;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && TX === 1'b0) begin
                repeat (BAUD / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                txq.push_back(b);
            end
            prev = TX;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] c, input int hold);
        @(negedge clk);
        cmd     = c;
        snd_cmd = 1'b1;
        repeat (hold) @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    task automatic wait_cmplt(input string name);
        int n;
        n = 0;
        while (cmd_cmplt !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(cmd_cmplt), 32'd1);
    endtask

    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(rdy), 32'd1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    // Drives one RX frame; optionally holds clr_rdy across the cycle rdy is set.
    task automatic rx_byte(input logic [7:0] d, input logic stop, input logic clr_at_stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BAUD) @(negedge clk);
        chk("rx_start_clears_rdy", 32'(rdy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BAUD) @(negedge clk);
        end
        rx_drv = stop;
        repeat (10) @(negedge clk);
        clr_rdy = clr_at_stop;
        @(negedge clk);
        clr_rdy = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic chk_txq(input string name, input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] got;
        got = 16'hxxxx;
        chk({name, "_count"}, 32'(txq.size()), 32'd2);
        if (txq.size() == 2) got = {txq[0], txq[1]};
        chk({name, "_bytes"}, 32'(got), 32'({hi, lo}));
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_rdy;
        logic [7:0] exp_data;
    } rx_vec_t;

    typedef struct {
        logic [15:0] c;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } tx_vec_t;

    rx_vec_t rxv[5];
    tx_vec_t txv[5];

    initial begin : main
        logic [7:0] prev_data;

        rxv[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
        rxv[1] = '{8'h00, 1'b1, 1'b1, 8'h00};
        rxv[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
`ifdef COMM_MASTER_FRAME_CHECK_EN
        rxv[3] = '{8'h3C, 1'b0, 1'b0, 8'hFF};
`else
        rxv[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C};
`endif
        rxv[4] = '{8'h81, 1'b1, 1'b1, 8'h81};

        txv[0] = '{16'h4BAF, 8'h4B, 8'hAF};
        txv[1] = '{16'h0B00, 8'h0B, 8'h00};
        txv[2] = '{16'hFFFF, 8'hFF, 8'hFF};
        txv[3] = '{16'h0001, 8'h00, 8'h01};
        txv[4] = '{16'h8000, 8'h80, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(TX), 32'd1);
        chk("reset_cmd_cmplt", 32'(cmd_cmplt), 32'd0);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        prev_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            pulse_clr();
            chk("rx_clr_rdy", 32'(rdy), 32'd0);
            chk("rx_data_hold", 32'(rx_data), 32'(prev_data));
            rx_byte(rxv[i].d, rxv[i].stop, 1'b0);
            $display("rx txn %0d: data=%h stop=%0d rdy=%0d rx_data=%h", i, rxv[i].d, rxv[i].stop, rdy, rx_data);
            chk("rx_rdy", 32'(rdy), 32'(rxv[i].exp_rdy));
            chk("rx_data", 32'(rx_data), 32'(rxv[i].exp_data));
            prev_data = rxv[i].exp_data;
        end

        pulse_clr();
        loop_en = 1'b1;
        send_cmd(16'h0B00, 1);
        wait_rdy("loop_rdy_hi");
        chk("loop_data_hi", 32'(rx_data), 32'h0B);
        pulse_clr();
        chk("loop_clr", 32'(rdy), 32'd0);
        wait_rdy("loop_rdy_lo");
        chk("loop_data_lo", 32'(rx_data), 32'h00);
        wait_cmplt("loop_cmplt");
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        $display("loopback txn: cmd=0b00 rx_data=%h", rx_data);

        rx_byte(8'h5A, 1'b1, 1'b1);
        chk("rx_set_beats_clr", 32'(rdy), 32'd1);
        chk("rx_set_beats_clr_data", 32'(rx_data), 32'h5A);

        for (int i = 0; i < 5; i++) begin
            txq.delete();
            send_cmd(txv[i].c, 1);
            chk("tx_cmplt_cleared", 32'(cmd_cmplt), 32'd0);
            wait_cmplt("tx_cmplt");
            repeat (20) @(negedge clk);
            $display("tx txn %0d: cmd=%h bytes_seen=%0d", i, txv[i].c, txq.size());
            chk_txq("tx", txv[i].hi, txv[i].lo);
        end

        txq.delete();
        @(negedge clk);
        cmd     = 16'h4BAF;
        snd_cmd = 1'b1;
        @(negedge clk);
        chk("tx_start_latency", 32'(TX), 32'd0);
        chk("tx_cmplt_drop", 32'(cmd_cmplt), 32'd0);
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (318) @(negedge clk);
        chk("tx_cmplt_early", 32'(cmd_cmplt), 32'd0);
        @(negedge clk);
        chk("tx_cmplt_320", 32'(cmd_cmplt), 32'd1);
        repeat (40) @(negedge clk);
        chk("tx_one_transfer_idle", 32'(TX), 32'd1);
        $display("timing txn: cmd=4baf bytes_seen=%0d", txq.size());
        chk_txq("tx_hold2", 8'h4B, 8'hAF);

        txq.delete();
        send_cmd(16'h4BAF, 1);
        repeat (40) @(negedge clk);
        cmd     = 16'h8100;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        wait_cmplt("ignore_cmplt");
        repeat (40) @(negedge clk);
        $display("ignore txn: cmd=8100 during 4baf bytes_seen=%0d", txq.size());
        chk_txq("tx_ignore", 8'h4B, 8'hAF);

        txq.delete();
        send_cmd(16'h4BAF, 1);
        repeat (100) @(negedge clk);
        chk("tx_bit5_pre_reset", 32'(TX), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_reset_tx", 32'(TX), 32'd1);
        chk("mid_reset_cmd_cmplt", 32'(cmd_cmplt), 32'd0);
        chk("mid_reset_rdy", 32'(rdy), 32'd0);
        chk("mid_reset_rx_data", 32'(rx_data), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (200) @(negedge clk);
        chk("post_reset_idle", 32'(TX), 32'd1);
        txq.delete();
        send_cmd(16'h1234, 1);
        wait_cmplt("post_reset_cmplt");
        repeat (20) @(negedge clk);
        $display("post-reset txn: cmd=1234 bytes_seen=%0d", txq.size());
        chk_txq("tx_post_reset", 8'h12, 8'h34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comm_master.md
# comm_master

Host-side command master for the logic-analyzer link. It takes a 16-bit command word and serializes it over a UART TX line as two 8N1 bytes, high byte first. It independently receives single response bytes on the RX line and presents them to the host-side logic with a ready/clear handshake. In simulation it stands in for the host PC and connects to the device-side UART wrapper.

## Interface
Parameters:
- BAUD_CNT, default 2604: clocks per UART bit; legal range 16–4095.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous and active-high (1 = reset). The name is kept for codebase consistency.
- cmd  in  16  command word; [15:8] is sent first.
- snd_cmd  in  1  request to send `cmd`; sampled only while idle.
- TX  out  1  serial output; idles high.
- cmd_cmplt  out  1  sticky flag: the last command has been fully transmitted.
- RX  in  1  asynchronous serial input.
- rdy  out  1  a received byte is valid in `rx_data`.
- rx_data  out  8  last received byte.
- clr_rdy  in  1  clears `rdy`.

## Operation
- Transmit FSM states:
  - IDLE: on `snd_cmd`, latch `cmd`, clear `cmd_cmplt`, go to HIGH.
  - HIGH: send `cmd[15:8]`; when its stop bit ends, go to LOW.
  - LOW: send `cmd[7:0]`; when its stop bit ends, set `cmd_cmplt` and go to IDLE.
- `snd_cmd` is ignored outside IDLE. Holding it high for several cycles starts exactly one transfer.
- The latched copy of `cmd` is used for the whole transfer. Changing `cmd` mid-transfer has no effect.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1.
- The LOW byte's start bit immediately follows the HIGH byte's stop bit, with no idle gap.
- Receiver:
  - RX passes through a 2-flop synchronizer.
  - In idle, a falling edge starts a frame.
  - Each bit is sampled at mid-bit (BAUD_CNT/2 clocks after the edge, then every BAUD_CNT clocks).
  - At the mid-stop-bit sample, the byte loads into `rx_data` and `rdy` is set.
- `rdy` clears on `clr_rdy` or on the next detected start bit. If a set and a clear occur in the same cycle, set wins.
- `rx_data` holds its value until the next byte completes.
- Transmitter and receiver run concurrently and independently.

## Timing
- Reset values: TX=1, cmd_cmplt=0, rdy=0, rx_data=8'h00, FSM=IDLE, receiver idle.
- The start bit of the HIGH byte drives TX on the clock after `snd_cmd` is sampled in IDLE.
- Each bit lasts exactly BAUD_CNT clocks.
- `cmd_cmplt` rises 20·BAUD_CNT clocks after the start bit begins.
- `rdy` rises about 9.5·BAUD_CNT + 2 clocks after the RX falling edge (synchronizer latency included).
- Reset asserted mid-operation aborts both directions immediately and returns to the reset values.
- A stop bit sampled low is handled as described under Configuration.

## Configuration
- Macro `COMM_MASTER_FRAME_CHECK_EN`:
  - Defined: a frame whose stop bit samples 0 is discarded; `rdy` and `rx_data` are unchanged, and the receiver returns to idle.
  - Undefined: the stop-bit value is ignored and the byte is always delivered.

## Structure
- Package `comm_pkg` holds:
  - the `tx_state_t` enum (IDLE, HIGH, LOW);
  - the receiver state enum;
  - the default-baud constant.
- One sub-module, `uart_tx`: byte serializer with `trmt`/`tx_data` inputs and a `tx_done` pulse. The FSM sequences two `uart_tx` transfers.
- The receiver is inline.

## Test plan
- BAUD_CNT=16, `cmd`=16'h4BAF, `snd_cmd` high for 2 cycles → TX carries 0x4B then 0xAF, LSB first. Exactly one transfer; `cmd_cmplt`=1 after 320 clocks.
- Drive RX with the byte 0xA5 → `rdy` rises and `rx_data`=8'hA5. Pulse `clr_rdy` → `rdy`=0 and `rx_data` stays 8'hA5.
- Loop TX to RX with `cmd`=16'h0B00 → two `rdy` events, `rx_data` 0x0B then 0x00 (clear between bytes).
- Pulse `snd_cmd` with 16'h8100 while in HIGH → ignored; the in-flight 16'h4BAF completes unchanged.
- Assert reset at bit 5 of the HIGH byte → TX=1 immediately and all outputs at reset values. A new send afterwards is correct.
- With `COMM_MASTER_FRAME_CHECK_EN` defined, RX byte 0x3C with stop bit 0 → `rdy` stays 0.
